cvsd_tdm_sched: RTL and testbench

Time-division scheduler that shares one CVSD step-adaptation datapath among NCH analog-sample requesters. Per-channel encoder state is held in a register bank: reconstructed value xp, step size, and the last two output bits. Requesters are arbitrated round-robin; each granted sample goes through a fixed 4-state sequence that emits one CVSD bit tagged with its channel. The block sits between the per-channel ADC sample buffers and the bitstream framer.

---
 rtl/cvsd_pkg.sv | 40 ++++
 rtl/cvsd_tdm_sched_if.sv | 24 ++
 rtl/cvsd_step_core.sv | 29 ++
 rtl/cvsd_tdm_sched.sv | 135 +++++++++++++
 tb/tb_cvsd_tdm_sched.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvsd_pkg.sv
// Shared types and defaults for the time-shared CVSD step-adaptation datapath.
package cvsd_pkg;

  localparam int unsigned BETA_DEF  = 48;
  localparam int unsigned DELTA_DEF = 1;
  localparam int unsigned STEP0_DEF = 10;
  localparam int unsigned XP0_DEF   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CALC  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  // h0 is the previous output bit, h1 the one before it
  typedef struct packed {
    logic [7:0] xp;
    logic [7:0] step;
    logic       h0;
    logic       h1;
  } cvsd_ch_state_t;

  localparam cvsd_ch_state_t CH_RST = '{
    xp:   8'(XP0_DEF),
    step: 8'(STEP0_DEF),
    h0:   1'b1,
    h1:   1'b0
  };

  function automatic cvsd_ch_state_t ch_init(input logic [7:0] xp0, input logic [7:0] step0);
    cvsd_ch_state_t s;
    s.xp   = xp0;
    s.step = step0;
    s.h0   = 1'b1;
    s.h1   = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/cvsd_tdm_sched_if.sv
// Requester/framer side bundle of the CVSD TDM scheduler.
interface cvsd_tdm_sched_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0]   ch_req;
  logic [8*NCH-1:0] x_in;
  logic [NCH-1:0]   ch_clr;
  logic [NCH-1:0]   ch_ack;
  logic             bit_valid;
  logic             bit_out;
  logic [2:0]       bit_ch;
  logic [7:0]       xp_out;
  logic [7:0]       step_out;

  modport master (
    output ch_req, x_in, ch_clr,
    input  ch_ack, bit_valid, bit_out, bit_ch, xp_out, step_out
  );

  modport slave (
    input  ch_req, x_in, ch_clr,
    output ch_ack, bit_valid, bit_out, bit_ch, xp_out, step_out
  );
endinterface

// File: rtl/cvsd_step_core.sv
// Single-sample CVSD step adaptation: comparator bit, 3-run detect, step decay/boost, xp update.
module cvsd_step_core
  import cvsd_pkg::*;
#(
  parameter int unsigned BETA  = BETA_DEF,
  parameter int unsigned DELTA = DELTA_DEF
) (
  input  logic [7:0]     x,
  input  cvsd_ch_state_t st,
  output logic           v2,
  output logic [7:0]     step_new,
  output logic [7:0]     xp_new
);

  logic        flag;
  logic [13:0] prod;
  logic [13:0] quo;

  always_comb begin
    v2   = (st.xp <= x);
    flag = (v2 == st.h0) && (v2 == st.h1);
    prod = 14'(BETA) * 14'(st.step);
    quo  = prod / 14'd50;
    step_new = quo[7:0] + (flag ? 8'(DELTA) : '0);
    // xp moves by the pre-update step and wraps modulo 256
    xp_new = v2 ? (st.xp + st.step) : (st.xp - st.step);
  end

endmodule

// File: rtl/cvsd_tdm_sched.sv
// Round-robin scheduler sharing one CVSD step core across NCH channels with a per-channel state bank.
module cvsd_tdm_sched
  import cvsd_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned BETA  = BETA_DEF,
  parameter int unsigned DELTA = DELTA_DEF,
  parameter int unsigned STEP0 = STEP0_DEF,
  parameter int unsigned XP0   = XP0_DEF
) (
  input  logic            clk_10k,
  input  logic            rst_n,
  input  logic            en,
  output logic            busy,
  cvsd_tdm_sched_if.slave bus
);

  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);
  localparam cvsd_ch_state_t CH_INIT = '{
    xp:   8'(XP0),
    step: 8'(STEP0),
    h0:   1'b1,
    h1:   1'b0
  };

  state_t         state, nstate;
  logic [GW-1:0]  g, rr, sel;
  logic           sel_ok;
  cvsd_ch_state_t bank [NCH];
  cvsd_ch_state_t w_st;
  logic [7:0]     w_x;
  logic           v2;
  logic [7:0]     step_new, xp_new;
  logic           r_bit;
  logic [2:0]     r_ch;
  logic [7:0]     r_xp, r_step;

  cvsd_step_core #(
    .BETA  (BETA),
    .DELTA (DELTA)
  ) u_core (
    .x        (w_x),
    .st       (w_st),
    .v2       (v2),
    .step_new (step_new),
    .xp_new   (xp_new)
  );

  // First requesting channel at or after the round-robin pointer
  always_comb begin : sel_blk
    int unsigned idx;
    idx    = 0;
    sel    = '0;
    sel_ok = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = (32'(rr) + i) % NCH;
      if (!sel_ok && bus.ch_req[idx]) begin
        sel_ok = 1'b1;
        sel    = GW'(idx);
      end
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (en && sel_ok) nstate = GRANT;
      GRANT:   nstate = CALC;
      CALC:    nstate = EMIT;
      EMIT:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    bus.bit_valid = (state == EMIT);
    bus.ch_ack    = (state == GRANT) ? (ONE_HOT0 << g) : '0;
    bus.bit_out   = r_bit;
    bus.bit_ch    = r_ch;
    bus.xp_out    = r_xp;
    bus.step_out  = r_step;
  end

  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      g      <= '0;
      rr     <= '0;
      w_x    <= '0;
      w_st   <= CH_INIT;
      r_bit  <= 1'b0;
      r_ch   <= '0;
      r_xp   <= '0;
      r_step <= '0;
    end else begin
      state <= nstate;
      case (state)
        IDLE: if (en && sel_ok) g <= sel;
        GRANT: begin
          w_x  <= bus.x_in[8*int'(g) +: 8];
          w_st <= bank[g];
        end
        CALC: begin
          r_bit  <= v2;
          r_ch   <= 3'(g);
          r_xp   <= xp_new;
          r_step <= step_new;
        end
        EMIT: rr <= (32'(g) == NCH - 1) ? '0 : g + 1'b1;
        default: ;
      endcase
    end
  end

  // Clear takes priority over the EMIT write-back of the same channel
  always_ff @(posedge clk_10k or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NCH; c++) bank[c] <= CH_INIT;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (bus.ch_clr[c]) begin
          bank[c] <= CH_INIT;
        end else if (state == EMIT && g == GW'(c)) begin
          bank[c].xp   <= r_xp;
          bank[c].step <= r_step;
          bank[c].h0   <= r_bit;
          bank[c].h1   <= w_st.h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cvsd_tdm_sched.sv
// Scoreboard bench for cvsd_tdm_sched: expectations queued at grant, checked at bit_valid.
module tb_cvsd_tdm_sched;
  import cvsd_pkg::*;

  localparam int NCH = 4;
  localparam int M_BETA = 48;
  localparam int M_DELTA = 1;

  logic             clk_10k = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             busy;
  logic [8*NCH-1:0] xv = '0;

  cvsd_tdm_sched_if #(.NCH(NCH)) bus();
  assign bus.x_in = xv;

  cvsd_tdm_sched #(.NCH(NCH)) dut (
    .clk_10k (clk_10k),
    .rst_n   (rst_n),
    .en      (en),
    .busy    (busy),
    .bus     (bus.slave)
  );

  always #5 clk_10k = ~clk_10k;

  typedef struct {
    int ch;
    int b;
    int xp;
    int step;
  } exp_t;

  exp_t sbq[$];
  exp_t ge;
  int   mxp[NCH], mstep[NCH], mh0[NCH], mh1[NCH];
  int   total = 0, bad = 0, cyc = 0, ack_ch = -1;
  bit   got_v;

  task automatic model_clear(input int c);
    mxp[c] = 128; mstep[c] = 10; mh0[c] = 1; mh1[c] = 0;
  endtask

  // One clock: sample #1 after the edge, queue an expectation on a grant, pop one on bit_valid
  task automatic tick();
    exp_t e;
    int x, v, fl;
    @(posedge clk_10k); #1;
    cyc++;
    ack_ch = -1;
    for (int c = 0; c < NCH; c++)
      if (bus.ch_ack[c] === 1'b1 && ack_ch < 0) ack_ch = c;
    if (ack_ch >= 0) begin
      x  = int'(xv[8*ack_ch +: 8]);
      v  = (mxp[ack_ch] <= x) ? 1 : 0;
      fl = (v == mh0[ack_ch] && v == mh1[ack_ch]) ? 1 : 0;
      e.ch   = ack_ch;
      e.b    = v;
      e.step = ((M_BETA * mstep[ack_ch]) / 50 + (fl ? M_DELTA : 0)) % 256;
      e.xp   = (v ? mxp[ack_ch] + mstep[ack_ch] : mxp[ack_ch] - mstep[ack_ch] + 256) % 256;
      mh1[ack_ch] = mh0[ack_ch]; mh0[ack_ch] = v;
      mxp[ack_ch] = e.xp; mstep[ack_ch] = e.step;
      sbq.push_back(e);
    end
    got_v = (bus.bit_valid === 1'b1);
    if (got_v) begin
      if (sbq.size() > 0) ge = sbq.pop_front();
      else begin ge.ch = -1; ge.b = -1; ge.xp = -1; ge.step = -1; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0;
    bus.ch_req = '0; bus.ch_clr = '0;
    sbq.delete();
    for (int c = 0; c < NCH; c++) model_clear(c);
    repeat (2) @(posedge clk_10k);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; bus.ch_req = '0; bus.ch_clr = '0;
    #3;
    total++;
    if ({bus.ch_ack, bus.bit_valid, bus.bit_out, bus.bit_ch, bus.xp_out, bus.step_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ack=%b v=%b bit=%b ch=%0d xp=%0d step=%0d want all 0",
               bus.ch_ack, bus.bit_valid, bus.bit_out, bus.bit_ch, bus.xp_out, bus.step_out);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    do_reset();
  endtask

  task automatic test_single();
    int kxp[3] = '{138, 147, 156};
    int nv = 0, ack_cyc = -100;
    do_reset();
    xv[7:0] = 8'd200; bus.ch_req = 4'b0001; en = 1'b1;
    for (int n = 0; n < 40 && nv < 3; n++) begin
      tick();
      if (ack_ch >= 0) ack_cyc = cyc;
      if (got_v) begin
        total++;
        if (cyc - ack_cyc != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", cyc - ack_cyc); end
        total++;
        if (bus.bit_ch !== 3'(ge.ch) || bus.bit_out !== 1'(ge.b) || bus.xp_out !== 8'(ge.xp) || bus.step_out !== 8'(ge.step)) begin
          bad++;
          $display("FAIL single_sb: got ch=%0d bit=%b xp=%0d step=%0d want ch=%0d bit=%0d xp=%0d step=%0d",
                   bus.bit_ch, bus.bit_out, bus.xp_out, bus.step_out, ge.ch, ge.b, ge.xp, ge.step);
        end
        total++;
        if (bus.bit_out !== 1'b1 || bus.xp_out !== 8'(kxp[nv]) || bus.step_out !== 8'd9) begin
          bad++;
          $display("FAIL single_const%0d: got bit=%b xp=%0d step=%0d want bit=1 xp=%0d step=9",
                   nv, bus.bit_out, bus.xp_out, bus.step_out, kxp[nv]);
        end
        nv++;
      end
    end
    total++;
    if (nv != 3) begin bad++; $display("FAIL single_count: got %0d valids want 3", nv); end
    bus.ch_req = '0;
  endtask

  task automatic test_all();
    int na = 0, nv = 0, last_v = -1;
    do_reset();
    xv = {8'd10, 8'd128, 8'd129, 8'd250};
    bus.ch_req = 4'b1111; en = 1'b1;
    for (int n = 0; n < 40 && nv < 4; n++) begin
      tick();
      if (ack_ch >= 0) begin
        total++;
        if (ack_ch != na) begin bad++; $display("FAIL all_ack_order: got %0d want %0d", ack_ch, na); end
        bus.ch_req[ack_ch] = 1'b0;
        na++;
      end
      if (got_v) begin
        if (last_v >= 0) begin
          total++;
          if (cyc - last_v != 4) begin bad++; $display("FAIL all_spacing: got %0d want 4", cyc - last_v); end
        end
        last_v = cyc;
        total++;
        if (bus.bit_ch !== 3'(nv) || bus.bit_out !== 1'(ge.b) || bus.xp_out !== 8'(ge.xp) || bus.step_out !== 8'(ge.step)) begin
          bad++;
          $display("FAIL all_sb: got ch=%0d bit=%b xp=%0d step=%0d want ch=%0d bit=%0d xp=%0d step=%0d",
                   bus.bit_ch, bus.bit_out, bus.xp_out, bus.step_out, nv, ge.b, ge.xp, ge.step);
        end
        nv++;
      end
    end
    total++;
    if (nv != 4) begin bad++; $display("FAIL all_count: got %0d valids want 4", nv); end
  endtask

  task automatic test_rr();
    int na = 0;
    int last[NCH] = '{-1, -1, -1, -1};
    do_reset();
    xv = '0; xv[7:0] = 8'd60; xv[23:16] = 8'd220;
    bus.ch_req = 4'b0101; en = 1'b1;
    for (int n = 0; n < 36; n++) begin
      tick();
      if (ack_ch >= 0) begin
        total++;
        if (ack_ch != ((na % 2 == 0) ? 0 : 2)) begin
          bad++; $display("FAIL rr_order: grant %0d got ch %0d want %0d", na, ack_ch, (na % 2 == 0) ? 0 : 2);
        end
        if (last[ack_ch] >= 0) begin
          total++;
          if (cyc - last[ack_ch] > 8) begin bad++; $display("FAIL rr_gap: got %0d want <=8", cyc - last[ack_ch]); end
        end
        last[ack_ch] = cyc;
        na++;
      end
      if (got_v) begin
        total++;
        if (bus.bit_ch !== 3'(ge.ch) || bus.bit_out !== 1'(ge.b) || bus.xp_out !== 8'(ge.xp) || bus.step_out !== 8'(ge.step)) begin
          bad++;
          $display("FAIL rr_sb: got ch=%0d bit=%b xp=%0d step=%0d want ch=%0d bit=%0d xp=%0d step=%0d",
                   bus.bit_ch, bus.bit_out, bus.xp_out, bus.step_out, ge.ch, ge.b, ge.xp, ge.step);
        end
      end
    end
    total++;
    if (na < 8) begin bad++; $display("FAIL rr_grants: got %0d want >=8", na); end
    bus.ch_req = '0;
  endtask

  task automatic test_clr();
    int nv = 0;
    do_reset();
    xv = '0; xv[7:0] = 8'd200;
    bus.ch_req = 4'b0001; en = 1'b1;
    for (int n = 0; n < 40 && nv < 3; n++) begin
      tick();
      bus.ch_clr = '0;
      if (got_v) begin
        total++;
        if (bus.bit_ch !== 3'(ge.ch) || bus.bit_out !== 1'(ge.b) || bus.xp_out !== 8'(ge.xp) || bus.step_out !== 8'(ge.step)) begin
          bad++;
          $display("FAIL clr_sb: got ch=%0d bit=%b xp=%0d step=%0d want ch=%0d bit=%0d xp=%0d step=%0d",
                   bus.bit_ch, bus.bit_out, bus.xp_out, bus.step_out, ge.ch, ge.b, ge.xp, ge.step);
        end
        nv++;
        if (nv == 2) begin
          total++;
          if (bus.xp_out !== 8'd147) begin bad++; $display("FAIL clr_emit_xp: got %0d want 147", bus.xp_out); end
          bus.ch_clr = 4'b0001;
          model_clear(0);
        end
        if (nv == 3) begin
          total++;
          if (bus.xp_out !== 8'd138 || bus.step_out !== 8'd9) begin
            bad++; $display("FAIL clr_after: got xp=%0d step=%0d want xp=138 step=9", bus.xp_out, bus.step_out);
          end
        end
      end
    end
    total++;
    if (nv != 3) begin bad++; $display("FAIL clr_count: got %0d valids want 3", nv); end
    bus.ch_req = '0; bus.ch_clr = '0;
  endtask

  task automatic test_en();
    int n;
    bit leak = 1'b0;
    do_reset();
    xv = '0; xv[15:8] = 8'd40; xv[31:24] = 8'd240;
    bus.ch_req = 4'b1010; en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ack_ch < 0 && n < 10);
    total++;
    if (ack_ch != 1) begin bad++; $display("FAIL en_first_ack: got %0d want 1", ack_ch); end
    tick();
    en = 1'b0;
    tick();
    total++;
    if (!got_v) begin
      bad++; $display("FAIL en_calc_valid: got bit_valid=0 want 1");
    end else if (bus.bit_ch !== 3'(ge.ch) || bus.xp_out !== 8'(ge.xp) || bus.step_out !== 8'(ge.step)) begin
      bad++;
      $display("FAIL en_calc_sb: got ch=%0d xp=%0d step=%0d want ch=%0d xp=%0d step=%0d",
               bus.bit_ch, bus.xp_out, bus.step_out, ge.ch, ge.xp, ge.step);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy !== 1'b0 || ack_ch >= 0 || got_v) leak = 1'b1;
    end
    total++;
    if (leak) begin bad++; $display("FAIL en_hold: got activity while en=0 want none"); end
    en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ack_ch < 0 && n < 10);
    total++;
    if (ack_ch != 3) begin bad++; $display("FAIL en_resume_ack: got %0d want 3", ack_ch); end
    tick(); tick();
    total++;
    if (!got_v || bus.bit_ch !== 3'(ge.ch) || bus.bit_out !== 1'(ge.b) || bus.xp_out !== 8'(ge.xp) || bus.step_out !== 8'(ge.step)) begin
      bad++;
      $display("FAIL en_resume_sb: got v=%b ch=%0d bit=%b xp=%0d step=%0d want ch=%0d bit=%0d xp=%0d step=%0d",
               got_v, bus.bit_ch, bus.bit_out, bus.xp_out, bus.step_out, ge.ch, ge.b, ge.xp, ge.step);
    end
    bus.ch_req = '0;
  endtask

  task automatic test_rst_mid();
    int n;
    bit aborted = 1'b0;
    do_reset();
    xv = '0; xv[7:0] = 8'd200;
    bus.ch_req = 4'b0001; en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!got_v && n < 10);
    total++;
    if (!got_v || bus.xp_out !== 8'd138) begin bad++; $display("FAIL rst_first: got v=%b xp=%0d want v=1 xp=138", got_v, bus.xp_out); end
    n = 0;
    do begin tick(); n++; end while (ack_ch < 0 && n < 10);
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ch_ack, bus.bit_valid, bus.bit_out, bus.bit_ch, bus.xp_out, bus.step_out, busy} !== '0) begin
      bad++;
      $display("FAIL rst_async: got ack=%b v=%b bit=%b ch=%0d xp=%0d step=%0d busy=%b want all 0",
               bus.ch_ack, bus.bit_valid, bus.bit_out, bus.bit_ch, bus.xp_out, bus.step_out, busy);
    end
    sbq.delete();
    for (int c = 0; c < NCH; c++) model_clear(c);
    repeat (3) begin
      @(posedge clk_10k); #1;
      if (bus.bit_valid !== 1'b0) aborted = 1'b1;
    end
    total++;
    if (aborted) begin bad++; $display("FAIL rst_abort: got bit_valid=1 want 0"); end
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!got_v && n < 12);
    total++;
    if (!got_v || bus.xp_out !== 8'd138 || bus.step_out !== 8'd9 || bus.xp_out !== 8'(ge.xp)) begin
      bad++;
      $display("FAIL rst_resume: got v=%b xp=%0d step=%0d want xp=138 step=9", got_v, bus.xp_out, bus.step_out);
    end
    bus.ch_req = '0;
  endtask

  initial begin
    bus.ch_req = '0;
    bus.ch_clr = '0;
    test_reset();
    test_single();
    test_all();
    test_rr();
    test_clr();
    test_en();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
